// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for a flagless single-clock FIFO.
// Mirrors the FIFO write strobe to track occupancy, issues read strobes
// while data is present, and absorbs the FIFO's one-cycle read latency in a
// two-entry skid buffer that feeds a valid/ready output stream.
module fifo_rd_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_mon,
    output logic          rd_en,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] occ_q, occ_d;
    logic [1:0]    buf_cnt_q, buf_cnt_d;
    logic          inflight_q, inflight_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;
    logic          pop;
    logic [2:0]    pending;

    // Read strobe: only while the FIFO holds data and the buffer will have room
    // for the returning word once this cycle's pop has been accounted for.
    always_comb begin
        pop     = (buf_cnt_q != 2'd0) && m_ready;
        pending = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en   = (occ_q != '0) && (pending < 3'd2);
    end

    // Occupancy tracking; a write into a full FIFO with no read is sticky overflow.
    always_comb begin
        occ_d      = occ_q;
        overflow_d = overflow_q;
        if (wr_en_mon && !rd_en) begin
            if (occ_q == DEPTH_C) begin
                overflow_d = 1'b1;
            end else begin
                occ_d = occ_q + CW'(1);
            end
        end else if (!wr_en_mon && rd_en) begin
            occ_d = occ_q - CW'(1);
        end
    end

    // Skid buffer: word returning from the FIFO is pushed, head is popped on accept.
    always_comb begin
        inflight_d = rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q;
        case ({inflight_q, pop})
            2'b01: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d    = fifo_dout;
                    buf_cnt_d = 2'd1;
                end else if (buf_cnt_q == 2'd1) begin
                    buf1_d    = fifo_dout;
                    buf_cnt_d = 2'd2;
                end
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_dout;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers, cleared asynchronously together with the FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            overflow_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    // Status and stream outputs come straight from registered state.
    always_comb begin
        m_valid  = (buf_cnt_q != 2'd0);
        m_data   = buf0_q;
        count    = occ_q + CW'(buf_cnt_q) + CW'(inflight_q);
        empty    = (occ_q == '0);
        full     = (occ_q == DEPTH_C);
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: drives fifo_rd_ctrl against a behavioural 16-deep FIFO,
// with a scoreboard queue of written words checked by an output monitor.
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int MAXC  = DEPTH + 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          wr_en_mon = 1'b0;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] wr_data   = '0;
    logic          rd_en;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    int            checks     = 0;
    int            errors     = 0;
    int            model_cnt  = 0;
    bit            check_data = 1'b1;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wp;
    logic [3:0]    rp;

    fifo_rd_ctrl #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_mon (wr_en_mon),
        .rd_en     (rd_en),
        .fifo_dout (fifo_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural flagless FIFO with registered read data, sharing rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            rp        <= '0;
            fifo_dout <= '0;
        end else begin
            if (wr_en_mon) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            if (rd_en) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 4'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic applyStimulus(input bit wr, input logic [DW-1:0] d, input bit rdy);
        @(posedge clk);
        #1;
        wr_en_mon = wr;
        wr_data   = d;
        m_ready   = rdy;
        if (wr) exp_q.push_back(d);
        @(negedge clk);
    endtask

    // Mid-cycle asynchronous reset with immediate output checks.
    task automatic doReset();
        #2;
        wr_en_mon = 1'b0;
        m_ready   = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("rst m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst rd_en", 32'(rd_en), 32'd0);
        checkOutput("rst count", 32'(count), 32'd0);
        checkOutput("rst empty", 32'(empty), 32'd1);
        checkOutput("rst full", 32'(full), 32'd0);
        checkOutput("rst overflow", 32'(overflow), 32'd0);
        checkOutput("rst m_data", 32'(m_data), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every accepted word and tracks count
    // as words written minus words delivered.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("count model", 32'(count), 32'(model_cnt));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    logic [DW-1:0] exp_word;
                    exp_word = exp_q.pop_front();
                    if (check_data) checkOutput("word order", 32'(m_data), 32'(exp_word));
                end
            end
            model_cnt = model_cnt + int'(wr_en_mon) - int'(m_valid && m_ready);
            if (model_cnt > MAXC) model_cnt = MAXC;
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        logic [DW-1:0] w [5];
        int first, last, nvalid, nrd;

        doReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("idle rd_en", 32'(rd_en), 32'd0);
        end
        checkOutput("idle empty", 32'(empty), 32'd1);

        // Single write with first-word latency.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("single rd_en W", 32'(rd_en), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("single rd_en", 32'(rd_en), 32'(c == 1));
            checkOutput("single m_valid", 32'(m_valid), 32'(c == 3));
            if (c == 3) checkOutput("single m_data", 32'(m_data), 32'hA5);
        end

        // Sixteen back-to-back writes at full throughput.
        first = -1; last = -1; nvalid = 0; nrd = 0;
        for (int c = 0; c < 26; c++) begin
            applyStimulus(c < 16, 8'(c), 1'b1);
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                nvalid++;
            end
            if (rd_en) nrd++;
        end
        checkOutput("burst valid count", 32'(nvalid), 32'd16);
        checkOutput("burst gap-free", 32'(last - first + 1), 32'd16);
        checkOutput("burst rd_en count", 32'(nrd), 32'd16);
        checkOutput("burst first latency", 32'(first), 32'd3);
        checkOutput("burst overflow", 32'(overflow), 32'd0);

        // Five words held back by a stalled consumer.
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom_range(0, 255));
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) applyStimulus(1'b1, w[c], 1'b0);
            else applyStimulus(1'b0, '0, 1'b0);
            if (rd_en) nrd++;
        end
        checkOutput("stall rd_en pulses", 32'(nrd), 32'd2);
        checkOutput("stall count", 32'(count), 32'd5);
        checkOutput("stall m_valid", 32'(m_valid), 32'd1);
        checkOutput("stall m_data held", 32'(m_data), 32'(w[0]));
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("release m_valid", 32'(m_valid), 32'(c < 5));
        end
        checkOutput("release drained", 32'(exp_q.size()), 32'd0);

        // Overflow: nineteen writes into a stalled path.
        check_data = 1'b0;
        for (int c = 0; c < 19; c++) begin
            applyStimulus(1'b1, 8'(c + 8'h40), 1'b0);
            if (c == 17) checkOutput("ovf full before 18th", 32'(full), 32'd0);
            if (c == 18) begin
                checkOutput("ovf full after 18th", 32'(full), 32'd1);
                checkOutput("ovf count after 18th", 32'(count), 32'd18);
                checkOutput("ovf not yet", 32'(overflow), 32'd0);
            end
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf set", 32'(overflow), 32'd1);
        checkOutput("ovf count", 32'(count), 32'd18);
        checkOutput("ovf full held", 32'(full), 32'd1);
        for (int c = 0; c < 30; c++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ovf sticky", 32'(overflow), 32'd1);
        checkOutput("ovf drained count", 32'(count), 32'd0);
        checkOutput("ovf drained empty", 32'(empty), 32'd1);
        doReset();
        check_data = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf cleared", 32'(overflow), 32'd0);

        // Reset in the middle of a stalled stream, then a single fresh word.
        for (int c = 0; c < 13; c++) begin
            applyStimulus(c < 9, 8'(c + 8'h80), 1'b0);
        end
        checkOutput("midrst count", 32'(count), 32'd9);
        checkOutput("midrst m_valid", 32'(m_valid), 32'd1);
        doReset();
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("post-rst m_valid W", 32'(m_valid), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("post-rst m_valid", 32'(m_valid), 32'(c == 3));
            if (c == 3) checkOutput("post-rst m_data", 32'(m_data), 32'h3C);
        end
        checkOutput("post-rst drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic kept below overflow.
        for (int c = 0; c < 400; c++) begin
            bit wr;
            wr = ($urandom_range(0, 1) == 1) && (model_cnt < DEPTH);
            applyStimulus(wr, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 40; c++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("random drained", 32'(exp_q.size()), 32'd0);
        checkOutput("random count", 32'(count), 32'd0);
        checkOutput("random overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
